mem_conf_ctrl: RTL and testbench
================================

MEM_CONF_CTRL -- requirements
Module: mem_conf_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 16384, meaning: word depth of each memory; valid word addresses are 0..MEM_WORDS-1.
REQ-002 clk  input  1  clock; all logic on posedge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  host command valid.
REQ-005 cmd_ready  output  1  controller accepts a command.
REQ-006 cmd_op  input  2  command: 00 write, 01 read, 10 start CPU, 11 stop CPU.
REQ-007 cmd_tgt  input  1  target memory: 0 instruction, 1 data.
REQ-008 cmd_addr  input  32  word address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response valid.
REQ-011 rsp_ready  input  1  host accepts response.
REQ-012 rsp_rdata  output  32  read data; 0 for non-read or error.
REQ-013 rsp_err  output  1  command rejected.
REQ-014 conf_sel  output  1  1 = data memory port A owned by configuration.
REQ-015 conf_addr  output  32  shared memory configuration address.
REQ-016 conf_wdata  output  32  shared memory configuration write data.
REQ-017 imem_conf_wren, imem_conf_rden  output  1 each  instruction memory write/read strobes.
REQ-018 dmem_conf_wren, dmem_conf_rden  output  1 each  data memory write/read strobes.
REQ-019 imem_conf_rdata, dmem_conf_rdata  input  32 each  memory read data, valid one cycle after the rden cycle.
REQ-020 cpu_resetn  output  1  CPU reset, active-low.
REQ-021 wr_cnt  output  16  count of successful memory writes.

Function
REQ-022 The FSM SHALL have states IDLE, WRITE, RD_ISSUE, RD_CAPT and RESP.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on a clock edge, and cmd fields are registered on that edge.
REQ-024 Write or read while cpu_resetn=1, or with cmd_addr>=MEM_WORDS, SHALL be rejected: no strobe is issued, go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 Valid write: WRITE holds the selected *_conf_wren=1 for exactly one cycle with conf_addr and conf_wdata set; wr_cnt increments (wraps 65535->0); then RESP with rsp_err=0.
REQ-026 Valid read: RD_ISSUE holds the selected *_conf_rden=1 for one cycle; RD_CAPT registers the selected *_conf_rdata into rsp_rdata; then RESP with rsp_err=0. Accept-to-rsp_valid latency is 3 cycles.
REQ-027 Start: cpu_resetn<=1 and conf_sel<=0 on the cycle entering RESP with rsp_err=0. Start while already running is a no-op with rsp_err=0.
REQ-028 Stop: cpu_resetn<=0, conf_sel<=1 and wr_cnt<=0 on entering RESP, with rsp_err=0.
REQ-029 conf_sel SHALL always equal ~cpu_resetn.
REQ-030 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL stay stable until rsp_ready=1; return to IDLE the cycle after the handshake. rsp_valid SHALL be 0 in all other states.
REQ-031 At most one strobe among the four *_conf_wren/rden SHALL be 1 in any cycle; all strobes SHALL be 0 outside WRITE and RD_ISSUE.
REQ-032 conf_addr and conf_wdata SHALL hold their last value when no strobe is active.

Reset
REQ-033 On resetn=0: state IDLE, cpu_resetn=0, conf_sel=1, all strobes 0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wr_cnt=0, conf_addr=0, conf_wdata=0.
REQ-034 Reset asserted mid-command SHALL abort the command and drop any pending response; no strobe completes after resetn falls.

Verification
REQ-035 After reset, write tgt=0 addr=5 data=0x00000013 -> imem_conf_wren pulses 1 cycle with addr 5; rsp_err=0; wr_cnt=1.
REQ-036 Write tgt=1 addr=3 data=0xDEADBEEF, then read tgt=1 addr=3 (memory model has 1-cycle latency) -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after accept.
REQ-037 Read addr=16384 -> no strobe, rsp_err=1, rsp_rdata=0.
REQ-038 Start, then write addr=0 -> cpu_resetn=1, conf_sel=0, write rejected with rsp_err=1; stop -> cpu_resetn=0, conf_sel=1, wr_cnt=0.
REQ-039 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and rsp_rdata stable, cmd_ready=0; an asserted cmd_valid is not accepted.
REQ-040 Assert resetn=0 during RD_ISSUE -> strobes 0 immediately; no response is produced after reset release.

Source files
------------

// File: rtl/mem_conf_ctrl.sv
// rtl/mem_conf_ctrl.sv - host configuration controller for CPU instruction/data memories
module mem_conf_ctrl #(
   parameter int unsigned MEM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic        cmd_tgt,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        conf_sel,
   output logic [31:0] conf_addr,
   output logic [31:0] conf_wdata,
   output logic        imem_conf_wren,
   output logic        imem_conf_rden,
   output logic        dmem_conf_wren,
   output logic        dmem_conf_rden,
   input  logic [31:0] imem_conf_rdata,
   input  logic [31:0] dmem_conf_rdata,
   output logic        cpu_resetn,
   output logic [15:0] wr_cnt
);

   localparam logic [1:0]  OP_WRITE = 2'b00;
   localparam logic [1:0]  OP_READ  = 2'b01;
   localparam logic [1:0]  OP_START = 2'b10;
   localparam logic [1:0]  OP_STOP  = 2'b11;
   localparam logic [31:0] ADDR_LIM = 32'(MEM_WORDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_ISSUE,
      ST_RD_CAPT,
      ST_RESP
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   tgt_q;
   logic   cmd_fire;
   logic   cmd_is_mem;
   logic   cmd_reject;

   // Memory access is only legal while the CPU is held in reset and the address fits
   assign cmd_fire   = cmd_valid && cmd_ready;
   assign cmd_is_mem = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);
   assign cmd_reject = cmd_is_mem && (cpu_resetn || (cmd_addr >= ADDR_LIM));

   // The configuration port owns data memory port A exactly while the CPU is held in reset
   assign conf_sel = ~cpu_resetn;

   // State register; async reset aborts any command in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus state-decoded handshakes and strobes (strobes drop as soon as reset forces IDLE)
   always_comb begin
      state_nxt      = state;
      cmd_ready      = 1'b0;
      rsp_valid      = 1'b0;
      imem_conf_wren = 1'b0;
      imem_conf_rden = 1'b0;
      dmem_conf_wren = 1'b0;
      dmem_conf_rden = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_is_mem && !cmd_reject) begin
                  state_nxt = (cmd_op == OP_WRITE) ? ST_WRITE : ST_RD_ISSUE;
               end else begin
                  state_nxt = ST_RESP;
               end
            end
         end
         ST_WRITE: begin
            imem_conf_wren = ~tgt_q;
            dmem_conf_wren = tgt_q;
            state_nxt      = ST_RESP;
         end
         ST_RD_ISSUE: begin
            imem_conf_rden = ~tgt_q;
            dmem_conf_rden = tgt_q;
            state_nxt      = ST_RD_CAPT;
         end
         ST_RD_CAPT: begin
            state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Command capture, response payload, CPU run control and write counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tgt_q      <= 1'b0;
         conf_addr  <= 32'd0;
         conf_wdata <= 32'd0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= 32'd0;
         cpu_resetn <= 1'b0;
         wr_cnt     <= 16'd0;
      end else begin
         if (cmd_fire) begin
            rsp_err   <= cmd_reject;
            rsp_rdata <= 32'd0;
            // Only accepted memory commands touch the shared config bus, so it holds otherwise
            if (cmd_is_mem && !cmd_reject) begin
               tgt_q     <= cmd_tgt;
               conf_addr <= cmd_addr;
               if (cmd_op == OP_WRITE) begin
                  conf_wdata <= cmd_wdata;
               end
            end
            if (cmd_op == OP_START) begin
               cpu_resetn <= 1'b1;
            end
            if (cmd_op == OP_STOP) begin
               cpu_resetn <= 1'b0;
               wr_cnt     <= 16'd0;
            end
         end
         if (state == ST_WRITE) begin
            wr_cnt <= wr_cnt + 16'd1;
         end
         // Memory returns data in the cycle after rden, which is this state
         if (state == ST_RD_CAPT) begin
            rsp_rdata <= tgt_q ? dmem_conf_rdata : imem_conf_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_conf_ctrl.sv
// tb/tb_mem_conf_ctrl.sv - directed self-checking bench for mem_conf_ctrl
module tb_mem_conf_ctrl;

   logic        clk;
   logic        resetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic        cmd_tgt;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        conf_sel;
   logic [31:0] conf_addr;
   logic [31:0] conf_wdata;
   logic        imem_conf_wren;
   logic        imem_conf_rden;
   logic        dmem_conf_wren;
   logic        dmem_conf_rden;
   logic [31:0] imem_conf_rdata;
   logic [31:0] dmem_conf_rdata;
   logic        cpu_resetn;
   logic [15:0] wr_cnt;

   int n_checks;
   int n_errors;

   int imem_wr_pulses;
   int imem_rd_pulses;
   int dmem_wr_pulses;
   int dmem_rd_pulses;
   int multi_strobe;
   int sel_mismatch;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   logic [31:0] imem [0:63];
   logic [31:0] dmem [0:63];

   logic [31:0] r_data;
   logic        r_err;
   int          r_lat;

   mem_conf_ctrl #(.MEM_WORDS(16384)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_tgt         (cmd_tgt),
      .cmd_addr        (cmd_addr),
      .cmd_wdata       (cmd_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .conf_sel        (conf_sel),
      .conf_addr       (conf_addr),
      .conf_wdata      (conf_wdata),
      .imem_conf_wren  (imem_conf_wren),
      .imem_conf_rden  (imem_conf_rden),
      .dmem_conf_wren  (dmem_conf_wren),
      .dmem_conf_rden  (dmem_conf_rden),
      .imem_conf_rdata (imem_conf_rdata),
      .dmem_conf_rdata (dmem_conf_rdata),
      .cpu_resetn      (cpu_resetn),
      .wr_cnt          (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories with one-cycle read latency
   always @(posedge clk) begin
      if (imem_conf_wren) imem[conf_addr[5:0]] <= conf_wdata;
      if (dmem_conf_wren) dmem[conf_addr[5:0]] <= conf_wdata;
      if (imem_conf_rden) imem_conf_rdata <= imem[conf_addr[5:0]];
      if (dmem_conf_rden) dmem_conf_rdata <= dmem[conf_addr[5:0]];
   end

   // Strobe and ownership monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_conf_wren) begin
         imem_wr_pulses++;
         last_waddr = conf_addr;
         last_wdata = conf_wdata;
      end
      if (dmem_conf_wren) begin
         dmem_wr_pulses++;
         last_waddr = conf_addr;
         last_wdata = conf_wdata;
      end
      if (imem_conf_rden) imem_rd_pulses++;
      if (dmem_conf_rden) dmem_rd_pulses++;
      if ((32'(imem_conf_wren) + 32'(imem_conf_rden) + 32'(dmem_conf_wren) + 32'(dmem_conf_rden)) > 1)
         multi_strobe++;
      if (conf_sel !== ~cpu_resetn) sel_mismatch++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one command, wait for its response, complete the handshake
   task automatic do_cmd(input logic [1:0] op, input logic tgt, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      int t;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_tgt   = tgt;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      t = 0;
      while (!cmd_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      lat = 1;
      forever begin
         @(negedge clk);
         if (rsp_valid || lat > 50) break;
         lat++;
      end
      if (lat > 50) check("rsp_timeout", 32'd0, 32'd1);
      rdata = rsp_rdata;
      err   = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      int stable_bad;
      int acc_bad;
      int t;
      int dw_before;
      int strobes_before;
      n_checks = 0;
      n_errors = 0;
      imem_wr_pulses = 0;
      imem_rd_pulses = 0;
      dmem_wr_pulses = 0;
      dmem_rd_pulses = 0;
      multi_strobe = 0;
      sel_mismatch = 0;
      last_waddr = 32'd0;
      last_wdata = 32'd0;
      imem_conf_rdata = 32'd0;
      dmem_conf_rdata = 32'd0;
      for (int i = 0; i < 64; i++) begin
         imem[i] = 32'd0;
         dmem[i] = 32'd0;
      end
      resetn    = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_tgt   = 1'b0;
      cmd_addr  = 32'd0;
      cmd_wdata = 32'd0;
      rsp_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
      check("rst_conf_sel", 32'(conf_sel), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      check("rst_conf_addr", conf_addr, 32'd0);
      check("rst_conf_wdata", conf_wdata, 32'd0);
      check("rst_strobes", {28'd0, imem_conf_wren, imem_conf_rden, dmem_conf_wren, dmem_conf_rden}, 32'd0);
      @(posedge clk);
      #1 resetn = 1'b1;

      // Instruction memory write
      do_cmd(2'b00, 1'b0, 32'd5, 32'h0000_0013, r_data, r_err, r_lat);
      check("iw_err", 32'(r_err), 32'd0);
      check("iw_rdata", r_data, 32'd0);
      check("iw_lat", 32'(r_lat), 32'd2);
      check("iw_pulses", 32'(imem_wr_pulses), 32'd1);
      check("iw_addr", last_waddr, 32'd5);
      check("iw_data", last_wdata, 32'h0000_0013);
      check("iw_wr_cnt", 32'(wr_cnt), 32'd1);

      // Data memory write then read back
      do_cmd(2'b00, 1'b1, 32'd3, 32'hDEAD_BEEF, r_data, r_err, r_lat);
      check("dw_err", 32'(r_err), 32'd0);
      check("dw_pulses", 32'(dmem_wr_pulses), 32'd1);
      check("dw_imem_untouched", 32'(imem_wr_pulses), 32'd1);
      check("dw_wr_cnt", 32'(wr_cnt), 32'd2);
      do_cmd(2'b01, 1'b1, 32'd3, 32'd0, r_data, r_err, r_lat);
      check("dr_rdata", r_data, 32'hDEAD_BEEF);
      check("dr_err", 32'(r_err), 32'd0);
      check("dr_lat", 32'(r_lat), 32'd3);
      check("dr_pulses", 32'(dmem_rd_pulses), 32'd1);
      check("dr_conf_wdata_held", conf_wdata, 32'hDEAD_BEEF);

      // Instruction memory read selects the other port
      do_cmd(2'b01, 1'b0, 32'd5, 32'd0, r_data, r_err, r_lat);
      check("ir_rdata", r_data, 32'h0000_0013);
      check("ir_pulses", 32'(imem_rd_pulses), 32'd1);

      // Address boundaries
      do_cmd(2'b00, 1'b1, 32'd16383, 32'h1234_5678, r_data, r_err, r_lat);
      check("wmax_err", 32'(r_err), 32'd0);
      check("wmax_wr_cnt", 32'(wr_cnt), 32'd3);
      strobes_before = imem_wr_pulses + imem_rd_pulses + dmem_wr_pulses + dmem_rd_pulses;
      do_cmd(2'b01, 1'b1, 32'd16384, 32'd0, r_data, r_err, r_lat);
      check("roob_err", 32'(r_err), 32'd1);
      check("roob_rdata", r_data, 32'd0);
      check("roob_lat", 32'(r_lat), 32'd1);
      do_cmd(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h5555_5555, r_data, r_err, r_lat);
      check("woob_err", 32'(r_err), 32'd1);
      check("oob_no_strobe", 32'(imem_wr_pulses + imem_rd_pulses + dmem_wr_pulses + dmem_rd_pulses),
            32'(strobes_before));
      check("oob_wr_cnt", 32'(wr_cnt), 32'd3);
      check("oob_conf_addr_held", conf_addr, 32'd16383);

      // Start, start again, rejected write while running, stop
      do_cmd(2'b10, 1'b0, 32'd0, 32'd0, r_data, r_err, r_lat);
      check("start_err", 32'(r_err), 32'd0);
      check("start_cpu_resetn", 32'(cpu_resetn), 32'd1);
      check("start_conf_sel", 32'(conf_sel), 32'd0);
      do_cmd(2'b10, 1'b0, 32'd0, 32'd0, r_data, r_err, r_lat);
      check("restart_err", 32'(r_err), 32'd0);
      check("restart_cpu_resetn", 32'(cpu_resetn), 32'd1);
      do_cmd(2'b00, 1'b0, 32'd0, 32'hAAAA_AAAA, r_data, r_err, r_lat);
      check("run_w_err", 32'(r_err), 32'd1);
      check("run_w_rdata", r_data, 32'd0);
      check("run_w_wr_cnt", 32'(wr_cnt), 32'd3);
      check("run_w_no_strobe", 32'(imem_wr_pulses), 32'd1);
      do_cmd(2'b11, 1'b0, 32'd0, 32'd0, r_data, r_err, r_lat);
      check("stop_err", 32'(r_err), 32'd0);
      check("stop_cpu_resetn", 32'(cpu_resetn), 32'd0);
      check("stop_conf_sel", 32'(conf_sel), 32'd1);
      check("stop_wr_cnt", 32'(wr_cnt), 32'd0);

      // Backpressure: response held 10 cycles, new command must wait
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_tgt   = 1'b1;
      cmd_addr  = 32'd3;
      @(posedge clk);
      #1 begin
         cmd_op    = 2'b00;
         cmd_addr  = 32'd7;
         cmd_wdata = 32'h0BAD_F00D;
      end
      t = 0;
      while (!rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      dw_before  = dmem_wr_pulses;
      stable_bad = 0;
      acc_bad    = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) stable_bad++;
         if (cmd_ready) acc_bad++;
      end
      check("bp_stable", 32'(stable_bad), 32'd0);
      check("bp_not_ready", 32'(acc_bad), 32'd0);
      check("bp_no_write", 32'(dmem_wr_pulses), 32'(dw_before));
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_back_idle", 32'(cmd_ready), 32'd1);
      check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);

      // Reset during RD_ISSUE
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_tgt   = 1'b1;
      cmd_addr  = 32'd3;
      @(posedge clk);
      #2 begin
         cmd_valid = 1'b0;
         check("abort_in_issue", 32'(dmem_conf_rden), 32'd1);
         resetn = 1'b0;
      end
      #1 check("abort_strobe_low",
               {28'd0, imem_conf_wren, imem_conf_rden, dmem_conf_wren, dmem_conf_rden}, 32'd0);
      repeat (2) @(negedge clk);
      #1 resetn = 1'b1;
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid || !cmd_ready) stable_bad++;
      end
      check("abort_no_rsp", 32'(stable_bad), 32'd0);

      check("one_hot_strobes", 32'(multi_strobe), 32'd0);
      check("conf_sel_tracks", 32'(sel_mismatch), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
